// File: rtl/render_pkg.sv
// Shared render types and constants: Q8.8 scalars, vertex vectors and the
// triangle sequencer state encoding.
package render_pkg;

  localparam logic [15:0] ONE           = 16'h0100;
  localparam int          VERTS_PER_TRI = 3;
  localparam int          WORDS_PER_TRI = 9;

  // [0]=x [1]=y [2]=z [3]=w
  typedef logic [3:0][15:0] vec4_t;
  // [0]=x [1]=y
  typedef logic [1:0][15:0] vec2_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/triangle_sequencer_if.sv
// Vertex RAM read port plus the screen-space triangle handshake toward the
// rasterizer. master = sequencer side, slave = RAM/rasterizer side.
interface triangle_sequencer_if #(
  parameter int ADDR_W = 16
);
  import render_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;

  logic              out_valid;
  logic              out_ready;
  vec2_t             out_V1;
  vec2_t             out_V2;
  vec2_t             out_V3;

  modport master (
    output mem_addr, mem_rd, out_valid, out_V1, out_V2, out_V3,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_valid, out_V1, out_V2, out_V3,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/triangle_sequencer.sv
// Walks a triangle list in vertex RAM, feeds each triangle to the external
// transform datapath, waits for it to settle and hands the result downstream.
module triangle_sequencer
  import render_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int CNT_W         = 12,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     tri_count,
  triangle_sequencer_if.master bus,
  output vec4_t                vertex_a,
  output vec4_t                vertex_b,
  output vec4_t                vertex_c,
  input  vec2_t                V1_in,
  input  vec2_t                V2_in,
  input  vec2_t                V3_in,
  output logic                 busy,
  output logic                 done
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [3:0]       K_LAST_RD  = 4'(WORDS_PER_TRI - 1);
  localparam logic [3:0]       K_LAST     = 4'(WORDS_PER_TRI);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] TRI_STRIDE = ADDR_W'(WORDS_PER_TRI);

  seq_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] tri_base_reg;
  logic [CNT_W-1:0]  tri_idx_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [3:0]        k_reg;
  logic [SET_W-1:0]  settle_reg;
  logic [15:0]       word_reg [WORDS_PER_TRI];
  vec2_t             out_v1_reg;
  vec2_t             out_v2_reg;
  vec2_t             out_v3_reg;

  logic last_tri;
  assign last_tri = (tri_idx_reg == count_reg - CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      tri_base_reg <= '0;
      tri_idx_reg  <= '0;
      count_reg    <= '0;
      k_reg        <= '0;
      settle_reg   <= '0;
      out_v1_reg   <= '0;
      out_v2_reg   <= '0;
      out_v3_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            tri_base_reg <= base_addr;
            addr_reg     <= base_addr;
            count_reg    <= tri_count;
            tri_idx_reg  <= '0;
            k_reg        <= '0;
            state_reg    <= (tri_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          // Address leads the data by one cycle; it stops at the last word.
          if (k_reg < K_LAST_RD) addr_reg <= addr_reg + ADDR_W'(1);
          if (k_reg == K_LAST) begin
            k_reg      <= '0;
            settle_reg <= '0;
            state_reg  <= SETTLE;
          end else begin
            k_reg <= k_reg + 4'd1;
          end
        end
        SETTLE: begin
          if (settle_reg == SET_LAST) begin
            out_v1_reg <= V1_in;
            out_v2_reg <= V2_in;
            out_v3_reg <= V3_in;
            state_reg  <= OUTPUT;
          end else begin
            settle_reg <= settle_reg + SET_W'(1);
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            if (last_tri) begin
              state_reg <= DONE;
            end else begin
              tri_idx_reg  <= tri_idx_reg + CNT_W'(1);
              tri_base_reg <= tri_base_reg + TRI_STRIDE;
              addr_reg     <= tri_base_reg + TRI_STRIDE;
              k_reg        <= '0;
              state_reg    <= FETCH;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM data for word k-1 arrives while the counter shows k.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < WORDS_PER_TRI; i++) word_reg[i] <= '0;
    end else if (state_reg == FETCH) begin
      for (int i = 0; i < WORDS_PER_TRI; i++) begin
        if (k_reg == 4'(i + 1)) word_reg[i] <= bus.mem_rdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comp
      assign vertex_a[gi] = word_reg[gi];
      assign vertex_b[gi] = word_reg[3 + gi];
      assign vertex_c[gi] = word_reg[6 + gi];
    end
  endgenerate

  assign vertex_a[3] = ONE;
  assign vertex_b[3] = ONE;
  assign vertex_c[3] = ONE;

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_rd    = (state_reg == FETCH) && (k_reg != K_LAST);
  assign bus.out_valid = (state_reg == OUTPUT);
  assign bus.out_V1    = out_v1_reg;
  assign bus.out_V2    = out_v2_reg;
  assign bus.out_V3    = out_v3_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer: per-cycle table for single-triangle
// runs plus hand-written back-pressure, empty-list and reset sequences.
module tb_triangle_sequencer;
  import render_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [15:0] base_addr;
  logic [11:0] tri_count;
  vec4_t       vertex_a, vertex_b, vertex_c;
  vec2_t       V1_in, V2_in, V3_in;
  logic        busy, done;

  triangle_sequencer_if #(.ADDR_W(16)) bus ();

  triangle_sequencer #(.ADDR_W(16), .CNT_W(12), .SETTLE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .tri_count(tri_count), .bus(bus), .vertex_a(vertex_a), .vertex_b(vertex_b),
    .vertex_c(vertex_c), .V1_in(V1_in), .V2_in(V2_in), .V3_in(V3_in),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Stand-in transform datapath: x' = x + z, y' = y ^ 0x00FF.
  function automatic vec2_t dp(input vec4_t v);
    vec2_t r;
    r[0] = v[0] + v[2];
    r[1] = v[1] ^ 16'h00FF;
    return r;
  endfunction

  assign V1_in = dp(vertex_a);
  assign V2_in = dp(vertex_b);
  assign V3_in = dp(vertex_c);

  logic [15:0] ram [0:65535];
  always @(posedge Clk) bus.mem_rdata <= bus.mem_rd ? ram[bus.mem_addr] : 16'hDEAD;

  function automatic vec4_t ram_vert(input logic [15:0] a);
    vec4_t v;
    v[0] = ram[a];
    v[1] = ram[16'(a + 16'd1)];
    v[2] = ram[16'(a + 16'd2)];
    v[3] = ONE;
    return v;
  endfunction

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic       rd;
    logic [3:0] off;
    logic       addr_chk;
    logic       valid;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t tbl [1:17];

  function automatic vec_t mk(input logic rd, input int off, input logic ac,
                              input logic v, input logic d, input logic b);
    vec_t e;
    e.rd = rd; e.off = 4'(off); e.addr_chk = ac; e.valid = v; e.dn = d; e.bsy = b;
    return e;
  endfunction

  // Single triangle with out_ready high; optionally a stray start in FETCH.
  task automatic run_table(input logic [15:0] base, input bit inject);
    logic [15:0] b3, b6;
    start = 1'b1; base_addr = base; tri_count = 12'd1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge Clk);
      check($sformatf("c%0d mem_rd", c), bus.mem_rd, tbl[c].rd);
      if (tbl[c].addr_chk)
        check($sformatf("c%0d mem_addr", c), bus.mem_addr, 16'(base + 16'(tbl[c].off)));
      check($sformatf("c%0d out_valid", c), bus.out_valid, tbl[c].valid);
      check($sformatf("c%0d done", c), done, tbl[c].dn);
      check($sformatf("c%0d busy", c), busy, tbl[c].bsy);
      if (c == 1) start = 1'b0;
      if (inject && c == 3) begin
        start = 1'b1; base_addr = 16'h0040; tri_count = 12'd5;
      end
      if (inject && c == 4) start = 1'b0;
    end
    b3 = 16'(base + 16'd3);
    b6 = 16'(base + 16'd6);
    check("vertex_a", vertex_a, ram_vert(base));
    check("vertex_b", vertex_b, ram_vert(b3));
    check("vertex_c", vertex_c, ram_vert(b6));
    check("out_V1..3", {bus.out_V1, bus.out_V2, bus.out_V3},
          {dp(ram_vert(base)), dp(ram_vert(b3)), dp(ram_vert(b6))});
  endtask

  task automatic check_scn1_values();
    check("s1 vertex_a", vertex_a, 64'h0100_0300_0200_0100);
    check("s1 vertex_b", vertex_b, 64'h0100_0600_0500_0400);
    check("s1 vertex_c", vertex_c, 64'h0100_0900_0800_0700);
    check("s1 out_V1", bus.out_V1, 32'h02FF_0400);
    check("s1 out_V2", bus.out_V2, 32'h05FF_0A00);
    check("s1 out_V3", bus.out_V3, 32'h08FF_1000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_rd"}, bus.mem_rd, 1'b0);
    check({tag, " mem_addr"}, bus.mem_addr, 16'h0000);
    check({tag, " out_valid"}, bus.out_valid, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " out_V"}, {bus.out_V1, bus.out_V2, bus.out_V3}, 96'h0);
    check({tag, " vertices"}, {vertex_a, vertex_b, vertex_c},
          {16'h0100, 48'h0, 16'h0100, 48'h0, 16'h0100, 48'h0});
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clk);
      start = 1'b0;
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL %s: out_valid timeout got 0 expected 1", tag);
    end
  endtask

  initial begin
    bit ok;
    vec4_t ea, eb, ec;

    for (int i = 0; i < 65536; i++) ram[i] = 16'(i * 16'h0137 + 16'h0005);
    for (int k = 0; k < 9; k++) ram[16'h0010 + k] = 16'((k + 1) << 8);

    tbl[1]  = mk(1, 0, 1, 0, 0, 1);
    tbl[2]  = mk(1, 1, 1, 0, 0, 1);
    tbl[3]  = mk(1, 2, 1, 0, 0, 1);
    tbl[4]  = mk(1, 3, 1, 0, 0, 1);
    tbl[5]  = mk(1, 4, 1, 0, 0, 1);
    tbl[6]  = mk(1, 5, 1, 0, 0, 1);
    tbl[7]  = mk(1, 6, 1, 0, 0, 1);
    tbl[8]  = mk(1, 7, 1, 0, 0, 1);
    tbl[9]  = mk(1, 8, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0);

    Reset = 1'b1; start = 1'b0; base_addr = '0; tri_count = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;
    @(negedge Clk);

    // Single triangle, hand-computed values.
    run_table(16'h0010, 1'b0);
    check_scn1_values();

    // Back-pressure on a two-triangle list.
    start = 1'b1; base_addr = 16'h0020; tri_count = 12'd2; bus.out_ready = 1'b0;
    wait_valid("bp tri0", ok);
    ea = ram_vert(16'h0020); eb = ram_vert(16'h0023); ec = ram_vert(16'h0026);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check($sformatf("bp hold%0d out_V", i), {bus.out_V1, bus.out_V2, bus.out_V3},
            {dp(ea), dp(eb), dp(ec)});
      check($sformatf("bp hold%0d vertices", i), {vertex_a, vertex_b, vertex_c}, {ea, eb, ec});
      check($sformatf("bp hold%0d valid/rd", i), {bus.out_valid, bus.mem_rd}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(negedge Clk);
    check("bp tri1 first rd", {bus.mem_rd, bus.out_valid}, 2'b10);
    check("bp tri1 first addr", bus.mem_addr, 16'h0029);
    wait_valid("bp tri1", ok);
    check("bp tri1 out_V", {bus.out_V1, bus.out_V2, bus.out_V3},
          {dp(ram_vert(16'h0029)), dp(ram_vert(16'h002C)), dp(ram_vert(16'h002F))});
    @(negedge Clk);
    check("bp done", {done, busy}, 2'b11);
    @(negedge Clk);
    check("bp idle", {done, busy}, 2'b00);

    // Empty list.
    start = 1'b1; base_addr = 16'h0100; tri_count = 12'd0;
    @(negedge Clk);
    start = 1'b0;
    check("cnt0 c1 done/busy/rd", {done, busy, bus.mem_rd}, 3'b110);
    @(negedge Clk);
    check("cnt0 c2 done/busy/rd", {done, busy, bus.mem_rd}, 3'b000);

    // Address wrap at the top of the address space.
    run_table(16'hFFFC, 1'b0);

    // Reset during SETTLE of the first triangle of three.
    start = 1'b1; base_addr = 16'h0010; tri_count = 12'd3; bus.out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("midrst");
    Reset = 1'b0;
    run_table(16'h0010, 1'b0);
    check_scn1_values();

    // Stray start with a different base and count during FETCH.
    run_table(16'h0010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
